// File: rtl/xc_clb_pkg.sv
// Shared encodings and helpers for the configurable logic block.
// Latency: n/a (constants/functions only).
// Backpressure: none.
package xc_clb_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_F    = 3'd1,
        SRC_G    = 3'd2,
        SRC_DI   = 3'd3,
        SRC_QX   = 3'd4,
        SRC_QY   = 3'd5,
        SRC_BAD  = 3'd6
    } src_t;

    // String parameters arrive as right-aligned ASCII in 32 bits; anything unknown maps to SRC_BAD.
    function automatic src_t src_decode(input logic [31:0] s);
        case (s)
            32'("NONE"): return SRC_NONE;
            32'("F"):    return SRC_F;
            32'("G"):    return SRC_G;
            32'("DI"):   return SRC_DI;
            32'("QX"):   return SRC_QX;
            32'("QY"):   return SRC_QY;
            default:     return SRC_BAD;
        endcase
    endfunction

    function automatic int lut_width(input int n_in);
        return 1 << (n_in - 1);
    endfunction

    function automatic logic src_mux(input src_t sel, input logic f, input logic g,
                                     input logic di, input logic qx, input logic qy);
        case (sel)
            SRC_F:   return f;
            SRC_G:   return g;
            SRC_QX:  return qx;
            SRC_QY:  return qy;
            default: return di;
        endcase
    endfunction

endpackage

// File: rtl/xc_clb_gen_ff.sv
// Single CLB flip-flop: reset > local reset/set > clock enable > hold.
// Latency: one K edge. Backpressure: none.
module xc_clb_gen_ff #(
    parameter bit INIT    = 1'b0,
    parameter bit CE_USED = 1'b1,
    parameter bit RD_USED = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic rd,
    input  logic ce,
    input  logic d,
    output logic q
);

    // Declaration value gives the power-up state before the first reset edge.
    logic q_reg = INIT;

    always_ff @(posedge clk) begin
        if (rst)
            q_reg <= INIT;
        else if (rd && RD_USED)
            q_reg <= INIT;
        else if (ce || !CE_USED)
            q_reg <= d;
    end

    assign q = q_reg;

endmodule

// File: rtl/xc_clb_gen.sv
// Parametrised CLB: two (N_IN-1)-input LUTs with optional F/G merge, two registered outputs.
// Latency: 0 cycles for F/G outputs, 1 cycle for QX/QY. Backpressure: none.
module xc_clb_gen
    import xc_clb_pkg::*;
#(
    parameter int                        N_IN    = 5,
    parameter logic [lut_width(N_IN)-1:0] F_INIT = '0,
    parameter logic [lut_width(N_IN)-1:0] G_INIT = '0,
    parameter bit                        MUX_FG  = 1'b0,
    parameter logic [31:0]               FB_F    = 32'("NONE"),
    parameter logic [31:0]               FB_G    = 32'("NONE"),
    parameter logic [31:0]               DX_SRC  = 32'("F"),
    parameter logic [31:0]               DY_SRC  = 32'("G"),
    parameter bit                        QX_INIT = 1'b0,
    parameter bit                        QY_INIT = 1'b0,
    parameter bit                        CE_USED = 1'b1,
    parameter bit                        RD_USED = 1'b1,
    parameter logic [31:0]               X_OUT   = 32'("F"),
    parameter logic [31:0]               Y_OUT   = 32'("QY")
) (
    input  logic            K,
    input  logic            R,
    input  logic [N_IN-1:0] IN,
    input  logic            DI,
    input  logic            EC,
    input  logic            RD,
    output logic            X,
    output logic            Y
);

    localparam int   LW     = N_IN - 1;
    localparam src_t FB_F_E = src_decode(FB_F);
    localparam src_t FB_G_E = src_decode(FB_G);
    localparam src_t DX_E   = src_decode(DX_SRC);
    localparam src_t DY_E   = src_decode(DY_SRC);
    localparam src_t X_E    = src_decode(X_OUT);
    localparam src_t Y_E    = src_decode(Y_OUT);

    if (N_IN < 3 || N_IN > 6) begin : g_bad_n_in
        $fatal(1, "xc_clb_gen: N_IN=%0d outside 3..6", N_IN);
    end
    if (MUX_FG && N_IN < 3) begin : g_bad_mux
        $fatal(1, "xc_clb_gen: MUX_FG=1 needs N_IN>=3");
    end
    if (!(FB_F_E inside {SRC_NONE, SRC_QX, SRC_QY}) ||
        !(FB_G_E inside {SRC_NONE, SRC_QX, SRC_QY})) begin : g_bad_fb
        $fatal(1, "xc_clb_gen: FB_F/FB_G must be NONE, QX or QY");
    end
    if (!(DX_E inside {SRC_F, SRC_G, SRC_DI}) ||
        !(DY_E inside {SRC_F, SRC_G, SRC_DI})) begin : g_bad_dsrc
        $fatal(1, "xc_clb_gen: DX_SRC/DY_SRC must be F, G or DI");
    end
    if (!(X_E inside {SRC_F, SRC_G, SRC_QX, SRC_QY}) ||
        !(Y_E inside {SRC_F, SRC_G, SRC_QX, SRC_QY})) begin : g_bad_out
        $fatal(1, "xc_clb_gen: X_OUT/Y_OUT must be F, G, QX or QY");
    end

    logic          qx, qy;
    logic [LW-1:0] f_idx, g_idx;
    logic          f_lut, g_lut, f_out, dx, dy;

    // Feedback takes over the top LUT input and sees the pre-edge Q, so no comb loop forms.
    always_comb begin
        f_idx = IN[LW-1:0];
        g_idx = IN[LW-1:0];
        if (FB_F_E == SRC_QX)
            f_idx[LW-1] = qx;
        else if (FB_F_E == SRC_QY)
            f_idx[LW-1] = qy;
        if (FB_G_E == SRC_QX)
            g_idx[LW-1] = qx;
        else if (FB_G_E == SRC_QY)
            g_idx[LW-1] = qy;
    end

    assign f_lut = F_INIT[f_idx];
    assign g_lut = G_INIT[g_idx];
    assign f_out = (MUX_FG && IN[N_IN-1]) ? g_lut : f_lut;

    assign dx = src_mux(DX_E, f_out, g_lut, DI, qx, qy);
    assign dy = src_mux(DY_E, f_out, g_lut, DI, qx, qy);

    xc_clb_gen_ff #(
        .INIT    (QX_INIT),
        .CE_USED (CE_USED),
        .RD_USED (RD_USED)
    ) u_ff_x (
        .clk (K),
        .rst (R),
        .rd  (RD),
        .ce  (EC),
        .d   (dx),
        .q   (qx)
    );

    xc_clb_gen_ff #(
        .INIT    (QY_INIT),
        .CE_USED (CE_USED),
        .RD_USED (RD_USED)
    ) u_ff_y (
        .clk (K),
        .rst (R),
        .rd  (RD),
        .ce  (EC),
        .d   (dy),
        .q   (qy)
    );

    assign X = src_mux(X_E, f_out, g_lut, DI, qx, qy);
    assign Y = src_mux(Y_E, f_out, g_lut, DI, qx, qy);

endmodule

// File: tb/tb_xc_clb_gen.sv
// Directed bench for xc_clb_gen: LUT truth tables, toggle/2-bit counters, reset priority.
// Several parameterisations share one clock; each has its own control inputs.
module tb_xc_clb_gen;

    logic K = 1'b0;
    always #5 K = ~K;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge K);
        #1;
    endtask

    // ---------------- combinational LUT instances ----------------
    logic [4:0] lut_in = 5'd0;
    logic and_x, and_y, mux_x, mux_y;

    xc_clb_gen #(.N_IN(5), .F_INIT(16'h8000), .X_OUT("F")) u_and (
        .K(K), .R(1'b0), .IN(lut_in), .DI(1'b0), .EC(1'b0), .RD(1'b0),
        .X(and_x), .Y(and_y));

    xc_clb_gen #(.N_IN(5), .F_INIT(16'h8000), .G_INIT(16'hFFFE), .MUX_FG(1'b1),
                 .X_OUT("F"), .Y_OUT("G")) u_mux (
        .K(K), .R(1'b0), .IN(lut_in), .DI(1'b0), .EC(1'b0), .RD(1'b0),
        .X(mux_x), .Y(mux_y));

    // ---------------- toggle flip-flop: F = !QX ----------------
    logic tog_r = 1'b0, tog_ec = 1'b0;
    logic tog_x, tog_y;

    xc_clb_gen #(.N_IN(3), .F_INIT(4'b0011), .FB_F("QX"), .DX_SRC("F"), .X_OUT("QX")) u_tog (
        .K(K), .R(tog_r), .IN(3'b000), .DI(1'b0), .EC(tog_ec), .RD(1'b0),
        .X(tog_x), .Y(tog_y));

    // ---------------- reset priority, RD unused ----------------
    logic rst_r = 1'b0, rst_ec = 1'b0, rst_rd = 1'b0;
    logic rst_x, rst_y;

    xc_clb_gen #(.N_IN(3), .DX_SRC("DI"), .QX_INIT(1'b1), .RD_USED(1'b0), .X_OUT("QX")) u_rst (
        .K(K), .R(rst_r), .IN(3'b000), .DI(1'b0), .EC(rst_ec), .RD(rst_rd),
        .X(rst_x), .Y(rst_y));

    // ---------------- simultaneous R/RD/EC on QY ----------------
    logic sim_r = 1'b0, sim_rd = 1'b0, sim_ec = 1'b0, sim_di = 1'b0;
    logic sim_x, sim_y;

    xc_clb_gen #(.N_IN(3), .DY_SRC("DI"), .QY_INIT(1'b0), .Y_OUT("QY")) u_sim (
        .K(K), .R(sim_r), .IN(3'b000), .DI(sim_di), .EC(sim_ec), .RD(sim_rd),
        .X(sim_x), .Y(sim_y));

    // ---------------- CE unused: loads every edge ----------------
    logic noce_di = 1'b0;
    logic noce_x, noce_y;

    xc_clb_gen #(.N_IN(3), .DX_SRC("DI"), .CE_USED(1'b0), .X_OUT("QX")) u_noce (
        .K(K), .R(1'b0), .IN(3'b000), .DI(noce_di), .EC(1'b0), .RD(1'b0),
        .X(noce_x), .Y(noce_y));

    // ---------------- two-bit counter: QX ^= 1, QY ^= QX ----------------
    logic cnt_r = 1'b0, cnt_ec = 1'b0, cnt_rd = 1'b0;
    logic cnt_x, cnt_y;
    logic [2:0] cnt_in;
    assign cnt_in = {2'b00, cnt_x};

    xc_clb_gen #(.N_IN(3), .F_INIT(4'b0011), .G_INIT(4'b0110), .FB_F("QX"), .FB_G("QY"),
                 .DX_SRC("F"), .DY_SRC("G"), .X_OUT("QX"), .Y_OUT("QY")) u_cnt (
        .K(K), .R(cnt_r), .IN(cnt_in), .DI(1'b0), .EC(cnt_ec), .RD(cnt_rd),
        .X(cnt_x), .Y(cnt_y));

    typedef struct {
        logic [4:0] in;
        logic       x_and;
        logic       x_mux;
        logic       y_mux;
    } lut_vec_t;

    lut_vec_t   lut_tab [12];
    logic [1:0] cnt_exp [8];

    initial begin
        lut_tab[0]  = '{5'h00, 1'b0, 1'b0, 1'b0};
        lut_tab[1]  = '{5'h0F, 1'b1, 1'b1, 1'b1};
        lut_tab[2]  = '{5'h07, 1'b0, 1'b0, 1'b1};
        lut_tab[3]  = '{5'h08, 1'b0, 1'b0, 1'b1};
        lut_tab[4]  = '{5'h10, 1'b0, 1'b0, 1'b0};
        lut_tab[5]  = '{5'h11, 1'b0, 1'b1, 1'b1};
        lut_tab[6]  = '{5'h1F, 1'b1, 1'b1, 1'b1};
        lut_tab[7]  = '{5'h1E, 1'b0, 1'b1, 1'b1};
        lut_tab[8]  = '{5'h0E, 1'b0, 1'b0, 1'b1};
        lut_tab[9]  = '{5'h18, 1'b0, 1'b1, 1'b1};
        lut_tab[10] = '{5'h01, 1'b0, 1'b0, 1'b1};
        lut_tab[11] = '{5'h17, 1'b0, 1'b1, 1'b1};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Power-up values before any clock edge.
        #1;
        check1("powerup_rst_x_init1", rst_x, 1'b1);
        check1("powerup_tog_x_init0", tog_x, 1'b0);

        // LUT truth tables, applied between edges.
        for (int i = 0; i < 12; i++) begin
            lut_in = lut_tab[i].in;
            #1;
            check1($sformatf("and_x[%0d]", i), and_x, lut_tab[i].x_and);
            check1($sformatf("mux_x[%0d]", i), mux_x, lut_tab[i].x_mux);
            check1($sformatf("mux_y[%0d]", i), mux_y, lut_tab[i].y_mux);
        end
        for (int v = 0; v < 16; v++) begin
            lut_in = {1'b1, 4'(v)};
            #1;
            check1($sformatf("sweep_and_x[%0d]", v), and_x, (v == 15));
            check1($sformatf("sweep_mux_x[%0d]", v), mux_x, (v != 0));
        end

        // Toggle counter.
        tick();
        tog_r = 1'b1; tog_ec = 1'b1;
        tick();
        check1("tog_reset", tog_x, 1'b0);
        tog_r = 1'b0;
        tick(); check1("tog_1", tog_x, 1'b1);
        tick(); check1("tog_2", tog_x, 1'b0);
        tick(); check1("tog_3", tog_x, 1'b1);
        tog_ec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("tog_hold[%0d]", i), tog_x, 1'b1);
        end
        tog_ec = 1'b1;
        tick(); check1("tog_resume", tog_x, 1'b0);
        tog_r = 1'b1;
        tick(); check1("tog_midop_reset", tog_x, 1'b0);
        tog_r = 1'b0;
        tick(); check1("tog_after_reset", tog_x, 1'b1);

        // Reset priority with QX_INIT=1, D=0; RD ignored.
        rst_ec = 1'b1;
        tick(); check1("rst_load0", rst_x, 1'b0);
        rst_r = 1'b1;
        tick(); check1("rst_pulse", rst_x, 1'b1);
        rst_r = 1'b0;
        tick(); check1("rst_release", rst_x, 1'b0);
        rst_rd = 1'b1;
        tick(); check1("rst_rd_unused", rst_x, 1'b0);
        rst_rd = 1'b0;

        // Simultaneous R, RD, EC with DI=1 on QY.
        sim_r = 1'b1; sim_rd = 1'b1; sim_ec = 1'b1; sim_di = 1'b1;
        tick(); check1("sim_all", sim_y, 1'b0);
        sim_r = 1'b0; sim_rd = 1'b0;
        tick(); check1("sim_load", sim_y, 1'b1);
        sim_rd = 1'b1;
        tick(); check1("sim_rd_over_ec", sim_y, 1'b0);
        sim_rd = 1'b0; sim_ec = 1'b0;
        tick(); check1("sim_ec_hold", sim_y, 1'b0);
        sim_ec = 1'b1;
        tick(); check1("sim_reload", sim_y, 1'b1);

        // CE unused: EC tied low but DI still loads.
        noce_di = 1'b1;
        tick(); check1("noce_load1", noce_x, 1'b1);
        noce_di = 1'b0;
        tick(); check1("noce_load0", noce_x, 1'b0);

        // Two-bit counter.
        cnt_r = 1'b1; cnt_ec = 1'b1;
        tick(); check2("cnt_reset", {cnt_y, cnt_x}, 2'd0);
        cnt_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check2($sformatf("cnt[%0d]", i), {cnt_y, cnt_x}, cnt_exp[i]);
        end
        tick(); tick();
        check2("cnt_before_rd", {cnt_y, cnt_x}, 2'd2);
        cnt_rd = 1'b1;
        tick(); check2("cnt_rd", {cnt_y, cnt_x}, 2'd0);
        cnt_rd = 1'b0;
        tick(); check2("cnt_after_rd", {cnt_y, cnt_x}, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
